unum4_addsub_seq: RTL and testbench
===================================

UNUM4_ADDSUB_SEQ -- requirements
Module: unum4_addsub_seq

Interface
REQ-001 SHALL have parameter MAN_MAX_W, default 29, mantissa width.
REQ-002 SHALL have parameter EXTRA, default 0, extra guard bits; W = MAN_MAX_W+EXTRA.
REQ-003 SHALL have parameter CHUNK_W, default 8, bits added per cycle; legal range 1..W+1.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, request to capture operands and begin.
REQ-008 SHALL have port op, input, 1, 0 = add, 1 = subtract (in1 - in2).
REQ-009 SHALL have port in1, input, W, signed two's-complement operand.
REQ-010 SHALL have port in2, input, W, signed two's-complement operand.
REQ-011 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-012 SHALL have port done, output, 1, single-cycle pulse marking a valid result.
REQ-013 SHALL have port out, output, W+1, signed result.
REQ-014 SHALL have port overflow, output, 1, result does not fit in W signed bits.

Function
REQ-015 SHALL compute NCHUNK = ceil((W+1)/CHUNK_W) at elaboration.
REQ-016 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-017 SHALL, in IDLE or DONE with start=1, capture op, in1 and in2 sign-extended to NCHUNK*CHUNK_W bits, and enter RUN.
REQ-018 SHALL form the second operand as in2 XOR {op} and preload carry = op.
REQ-019 SHALL add one CHUNK_W slice per RUN cycle, LSB first, registering carry-out as the next carry-in.
REQ-020 SHALL ignore start while in RUN; captured operands SHALL NOT change.
REQ-021 SHALL go RUN -> DONE after the NCHUNK-th slice, then DONE -> IDLE unless start=1.
REQ-022 SHALL, for start accepted at edge t, assert done for exactly one cycle after edge t+NCHUNK.
REQ-023 SHALL hold busy=1 from the cycle after acceptance until done asserts; busy=0 in DONE and IDLE.
REQ-024 SHALL update out to the low W+1 bits of the sum, and overflow = out[W] XOR out[W-1], only when entering DONE.
REQ-025 SHALL hold out and overflow stable until the next completion or reset.
REQ-026 SHALL, for start in DONE, pulse done normally and begin the new operation without an idle cycle.

Reset
REQ-027 SHALL, on rst=1, enter IDLE and clear busy, done, out, overflow, carry and operand registers to 0.
REQ-028 SHALL, on rst during RUN, abort the operation with no done pulse.
REQ-029 SHALL give rst priority over start in the same cycle.

Configuration
REQ-030 SHALL, with UNUM4_ADDSUB_SAT_EN defined, replace out on overflow with the W-bit saturated value sign-extended to W+1 bits: +(2^(W-1)-1) if out[W]=0, else -2^(W-1); overflow still asserts.
REQ-031 SHALL, without UNUM4_ADDSUB_SAT_EN, output the exact W+1-bit result, add no saturation logic and keep the same latency.

Structure
REQ-032 SHALL place the FSM state encodings and the NCHUNK ceiling-division function in the shared unum4 package/header.
REQ-033 SHALL instantiate one sub-module, unum4_chunk_add, as a CHUNK_W-bit adder with carry-in and carry-out.

Verification (MAN_MAX_W=29, EXTRA=0, CHUNK_W=8, so W=29 and NCHUNK=4, unless stated)
REQ-034 SHALL check: start, op=0, in1=5, in2=3 -> done at edge t+4, out=8, overflow=0, busy high for 4 cycles.
REQ-035 SHALL check: op=1, in1=5, in2=7 -> out=-2 (all ones except bit 0), overflow=0.
REQ-036 SHALL check: op=0, in1=0x0FFFFFFF, in2=1 -> out=0x10000000, overflow=1; with SAT_EN, out=0x0FFFFFFF.
REQ-037 SHALL check: op=1, in1=-2^28, in2=1 -> out=-2^28-1, overflow=1; with SAT_EN, out=-2^28.
REQ-038 SHALL check: start pulsed mid-RUN with new operands -> ignored and first result unchanged; back-to-back start in DONE -> second done exactly 4 cycles later.
REQ-039 SHALL check: rst at the 2nd RUN cycle -> no done, outputs 0, IDLE; repeat REQ-034 with CHUNK_W=1 (30 cycles) and CHUNK_W=30 (1 cycle).

Source files
------------

// File: rtl/unum4_addsub_seq_pkg.sv
// ============================================================================
// Module      : unum4_addsub_seq_pkg
// Description : Shared FSM state encoding and elaboration helpers for the
//               chunked sequential add/subtract unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package unum4_addsub_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int f_ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

`default_nettype wire

// File: rtl/unum4_chunk_add.sv
// ============================================================================
// Module      : unum4_chunk_add
// Description : CHUNK_W-bit ripple slice adder with carry-in and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unum4_chunk_add #(
    parameter int CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] i_a,
    input  logic [CHUNK_W-1:0] i_b,
    input  logic               i_cin,
    output logic [CHUNK_W-1:0] o_sum,
    output logic               o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK_W{1'b0}}, i_cin};

endmodule

`default_nettype wire

// File: rtl/unum4_addsub_seq.sv
// ============================================================================
// Module      : unum4_addsub_seq
// Description : Sequential signed add/subtract, CHUNK_W bits per cycle, LSB
//               first. Define UNUM4_ADDSUB_SAT_EN to saturate on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unum4_addsub_seq #(
    parameter int MAN_MAX_W = 29,
    parameter int EXTRA     = 0,
    parameter int CHUNK_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         op,
    input  logic [MAN_MAX_W+EXTRA-1:0]   in1,
    input  logic [MAN_MAX_W+EXTRA-1:0]   in2,
    output logic                         busy,
    output logic                         done,
    output logic [MAN_MAX_W+EXTRA:0]     out,
    output logic                         overflow
);

    import unum4_addsub_seq_pkg::*;

    localparam int c_w      = MAN_MAX_W + EXTRA;
    localparam int c_nchunk = f_ceil_div(c_w + 1, CHUNK_W);
    localparam int c_tot    = c_nchunk * CHUNK_W;
    localparam int c_cnt_w  = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;

    state_t               r_state;
    logic [c_tot-1:0]     r_a;
    logic [c_tot-1:0]     r_b;
    logic [c_tot-1:0]     r_sum;
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [c_w:0]         r_out;
    logic                 r_ovf;

    logic [c_tot-1:0]     w_sum_next;
    logic [CHUNK_W-1:0]   w_a_chunk;
    logic [CHUNK_W-1:0]   w_b_chunk;
    logic [CHUNK_W-1:0]   w_chunk_sum;
    logic                 w_cout;
    logic                 w_last;
    logic                 w_ovf;
    logic [c_w:0]         w_res;

    unum4_chunk_add #(
        .CHUNK_W (CHUNK_W)
    ) u_chunk_add (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_sum  (w_chunk_sum),
        .o_cout (w_cout)
    );

    // The completed sum, including the slice being added this cycle
    always_comb begin
        w_a_chunk  = r_a[int'(r_cnt)*CHUNK_W +: CHUNK_W];
        w_b_chunk  = r_b[int'(r_cnt)*CHUNK_W +: CHUNK_W];
        w_sum_next = r_sum;
        w_sum_next[int'(r_cnt)*CHUNK_W +: CHUNK_W] = w_chunk_sum;
        w_last     = (r_cnt == c_cnt_w'(c_nchunk - 1));
        w_ovf      = w_sum_next[c_w] ^ w_sum_next[c_w-1];
        w_res      = w_sum_next[c_w:0];
`ifdef UNUM4_ADDSUB_SAT_EN
        if (w_ovf) begin
            w_res = w_sum_next[c_w] ? {2'b11, {(c_w-1){1'b0}}}
                                    : {2'b00, {(c_w-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is in1 + ~in2 + 1
                        r_a     <= {{(c_tot-c_w){in1[c_w-1]}}, in1};
                        r_b     <= {{(c_tot-c_w){in2[c_w-1]}}, in2} ^ {c_tot{op}};
                        r_carry <= op;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_out   <= w_res;
                        r_ovf   <= w_ovf;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign out      = r_out;
    assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_unum4_addsub_seq.sv
// ============================================================================
// Module      : tb_unum4_addsub_seq
// Description : Directed self-checking bench for unum4_addsub_seq with
//               CHUNK_W = 8, 1 and 30 (W = 29).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unum4_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [28:0] in1;
    logic [28:0] in2;

    logic        busy8,  done8,  ovf8;
    logic [29:0] out8;
    logic        busy1,  done1,  ovf1;
    logic [29:0] out1;
    logic        busy30, done30, ovf30;
    logic [29:0] out30;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    unum4_addsub_seq #(.MAN_MAX_W(29), .EXTRA(0), .CHUNK_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
        .busy(busy8), .done(done8), .out(out8), .overflow(ovf8));

    unum4_addsub_seq #(.MAN_MAX_W(29), .EXTRA(0), .CHUNK_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
        .busy(busy1), .done(done1), .out(out1), .overflow(ovf1));

    unum4_addsub_seq #(.MAN_MAX_W(29), .EXTRA(0), .CHUNK_W(30)) u_dut30 (
        .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
        .busy(busy30), .done(done30), .out(out30), .overflow(ovf30));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with start for one edge; returns 1ns after that edge
    task automatic issue(input logic o, input logic [28:0] a, input logic [28:0] b);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        step();
        start = 1'b0;
    endtask

    task automatic expect_done8(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, 64'(busy8), 64'd1);
            check({tag, "_nodone"}, 64'(done8), 64'd0);
            step();
        end
        check({tag, "_done"}, 64'(done8), 64'd1);
        check({tag, "_busy_lo"}, 64'(busy8), 64'd0);
    endtask

    initial begin
        logic [29:0] exp_ovf_pos;
        logic [29:0] exp_ovf_neg;
        int          lat1;
        int          lat30;
        logic [29:0] res30;

`ifdef UNUM4_ADDSUB_SAT_EN
        exp_ovf_pos = 30'h0FFFFFFF;
        exp_ovf_neg = 30'h30000000;
`else
        exp_ovf_pos = 30'h10000000;
        exp_ovf_neg = 30'h2FFFFFFF;
`endif

        rst = 1'b1; start = 1'b0; op = 1'b0; in1 = '0; in2 = '0;
        step(); step();
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_out",  64'(out8),  64'd0);
        check("rst_ovf",  64'(ovf8),  64'd0);
        rst = 1'b0;
        step();

        // 5 + 3
        issue(1'b0, 29'd5, 29'd3);
        expect_done8("add", 4);
        check("add_out", 64'(out8), 64'd8);
        check("add_ovf", 64'(ovf8), 64'd0);
        step();
        check("add_pulse", 64'(done8), 64'd0);
        check("add_hold",  64'(out8),  64'd8);

        // 5 - 7
        issue(1'b1, 29'd5, 29'd7);
        expect_done8("sub", 4);
        check("sub_out", 64'(out8), 64'h3FFFFFFE);
        check("sub_ovf", 64'(ovf8), 64'd0);
        step();

        // positive overflow
        issue(1'b0, 29'h0FFFFFFF, 29'd1);
        expect_done8("povf", 4);
        check("povf_out", 64'(out8), 64'(exp_ovf_pos));
        check("povf_ovf", 64'(ovf8), 64'd1);
        step();

        // negative overflow: -2^28 - 1
        issue(1'b1, 29'h10000000, 29'd1);
        expect_done8("novf", 4);
        check("novf_out", 64'(out8), 64'(exp_ovf_neg));
        check("novf_ovf", 64'(ovf8), 64'd1);
        step();

        // start mid-RUN ignored, then back-to-back start in DONE
        issue(1'b0, 29'd5, 29'd3);
        step();
        start = 1'b1; op = 1'b1; in1 = 29'd100; in2 = 29'd200;
        step();
        start = 1'b0;
        check("mid_busy", 64'(busy8), 64'd1);
        step();
        step();
        check("mid_done", 64'(done8), 64'd1);
        check("mid_out",  64'(out8),  64'd8);
        issue(1'b1, 29'd5, 29'd7);
        expect_done8("b2b", 4);
        check("b2b_out", 64'(out8), 64'h3FFFFFFE);
        step();

        // reset in the 2nd RUN cycle aborts
        issue(1'b0, 29'd5, 29'd3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_done", 64'(done8), 64'd0);
        check("abort_out",  64'(out8),  64'd0);
        check("abort_ovf",  64'(ovf8),  64'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("abort_nodone", 64'(done8), 64'd0);
        end

        // reset wins over start in the same cycle
        rst = 1'b1; start = 1'b1; op = 1'b0; in1 = 29'd1; in2 = 29'd1;
        step();
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", 64'(busy8), 64'd0);
        step();
        check("rst_prio_idle", 64'(busy8), 64'd0);

        // CHUNK_W = 1 and 30 latency
        lat1 = -1; lat30 = -1; res30 = '0;
        issue(1'b0, 29'd5, 29'd3);
        check("c30_busy", 64'(busy30), 64'd1);
        check("c1_busy",  64'(busy1),  64'd1);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (done1 && lat1 < 0) lat1 = k;
            if (done30 && lat30 < 0) begin
                lat30 = k;
                res30 = out30;
            end
        end
        check("c1_lat",  64'(lat1),  64'd30);
        check("c1_out",  64'(out1),  64'd8);
        check("c30_lat", 64'(lat30), 64'd1);
        check("c30_out", 64'(res30), 64'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
